// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared state encodings and 8N1 framing constants for uart_phy.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 8N1 framing: eight data bits between one start and one stop bit
    localparam int         c_DATA_BITS    = 8;
    localparam logic [2:0] c_LAST_BIT_IDX = 3'(c_DATA_BITS - 1);

    // Receive framing state
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    // Transmit framing state
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Hand-off of the received byte to the 8250 core
    typedef enum logic [1:0] {
        DLV_EMPTY = 2'd0,
        DLV_OFFER = 2'd1,
        DLV_WAIT  = 2'd2
    } dlv_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_bit_timer
// Brief    : Reloadable down-counter. Loading value N-1 makes oTc assert for
//            one cycle so that the consumer sees it N rising edges later.
// Revision : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iLoadVal,
    output logic             oTc
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_run;

    // Count down while running; a reload always wins over expiry
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (iLoad) begin
            r_cnt <= iLoadVal;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign oTc = r_run && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_phy.sv
`default_nettype none
// ============================================================================
// Module   : uart_phy
// Brief    : Full-duplex 8N1 serial PHY for an 8250-style core: synchronised
//            receiver with one-byte holding buffer and offer/accept delivery,
//            plus an independent transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_phy
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       iClk,
    input  logic       iRstN,
    input  logic       iUartRx,
    output logic       oUartTx,
    output logic [7:0] oRxData,
    output logic       oRx,
    input  logic       iRxReady,
    input  logic       iRxTaken,
    output logic       oTxReady,
    input  logic [7:0] iTxData,
    input  logic       iTx,
    output logic       oFrameErr,
    output logic       oOverrun
);

    // Timers are loaded with (cycles - 1) so a full bit time fits the width
    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_FULL_LOAD = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LOAD = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------------
    logic               r_rx_meta;
    logic               r_rx_sync;
    rx_state_t          r_rx_state;
    rx_state_t          w_rx_state_nxt;
    logic [7:0]         r_rx_shift;
    logic [7:0]         w_rx_shift_nxt;
    logic [2:0]         r_rx_idx;
    logic [2:0]         w_rx_idx_nxt;
    logic               w_rx_load;
    logic [c_CNT_W-1:0] w_rx_load_val;
    logic               w_rx_tc;
    logic               w_rx_store;
    logic               w_rx_frame_err;
    logic               r_frame_err;

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= iUartRx;
            r_rx_sync <= r_rx_meta;
        end
    end

    uart_bit_timer #(
        .WIDTH    (c_CNT_W)
    ) u_rx_timer (
        .iClk     (iClk),
        .iRstN    (iRstN),
        .iLoad    (w_rx_load),
        .iLoadVal (w_rx_load_val),
        .oTc      (w_rx_tc)
    );

    // RX framing: find the start edge, sample mid-bit, check the stop bit
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_idx_nxt   = r_rx_idx;
        w_rx_load      = 1'b0;
        w_rx_load_val  = c_FULL_LOAD;
        w_rx_store     = 1'b0;
        w_rx_frame_err = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (!r_rx_sync) begin
                    w_rx_state_nxt = RX_START;
                    w_rx_load      = 1'b1;
                    w_rx_load_val  = c_HALF_LOAD;
                end
            end
            RX_START: begin
                if (w_rx_tc) begin
                    if (!r_rx_sync) begin
                        w_rx_state_nxt = RX_DATA;
                        w_rx_idx_nxt   = 3'd0;
                        w_rx_load      = 1'b1;
                    end else begin
                        // Line went back high before mid start bit: glitch
                        w_rx_state_nxt = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (w_rx_tc) begin
                    w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
                    w_rx_load      = 1'b1;
                    if (r_rx_idx == c_LAST_BIT_IDX) begin
                        w_rx_state_nxt = RX_STOP;
                    end else begin
                        w_rx_idx_nxt = r_rx_idx + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (w_rx_tc) begin
                    if (r_rx_sync) begin
                        w_rx_store     = 1'b1;
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_rx_frame_err = 1'b1;
                        w_rx_state_nxt = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                // Hold off until the line returns to idle so a long low
                // level is not decoded as a stream of zero bytes
                if (r_rx_sync) begin
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: begin
                w_rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    // RX framing state register
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            r_rx_state  <= RX_IDLE;
            r_rx_shift  <= 8'h00;
            r_rx_idx    <= 3'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_state  <= w_rx_state_nxt;
            r_rx_shift  <= w_rx_shift_nxt;
            r_rx_idx    <= w_rx_idx_nxt;
            r_frame_err <= w_rx_frame_err;
        end
    end

    // ------------------------------------------------------------------------
    // Holding buffer and delivery to the core
    // ------------------------------------------------------------------------
    logic [7:0] r_buf;
    logic       r_full;
    logic       r_overrun;
    dlv_state_t r_dlv_state;
    dlv_state_t w_dlv_state_nxt;
    logic [1:0] r_wait_cnt;
    logic [1:0] w_wait_cnt_nxt;
    logic       w_rx_strobe;
    logic       r_rx_strobe;
    logic       w_buf_clear;

    // Delivery: offer when the core is ready, allow two cycles for the take
    always_comb begin
        w_dlv_state_nxt = r_dlv_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_rx_strobe     = 1'b0;
        w_buf_clear     = 1'b0;
        case (r_dlv_state)
            DLV_EMPTY: begin
                if (r_full) begin
                    w_dlv_state_nxt = DLV_OFFER;
                end
            end
            DLV_OFFER: begin
                if (iRxReady) begin
                    w_rx_strobe     = 1'b1;
                    w_wait_cnt_nxt  = 2'd0;
                    w_dlv_state_nxt = DLV_WAIT;
                end
            end
            DLV_WAIT: begin
                // Count 0 is the strobe cycle itself; the take window is
                // the two cycles that follow it
                if ((r_wait_cnt != 2'd0) && iRxTaken) begin
                    w_buf_clear     = 1'b1;
                    w_dlv_state_nxt = DLV_EMPTY;
                end else if (r_wait_cnt == 2'd2) begin
                    w_dlv_state_nxt = DLV_OFFER;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 2'd1;
                end
            end
            default: begin
                w_dlv_state_nxt = DLV_EMPTY;
            end
        endcase
    end

    // Buffer fill/drain; a store racing a clear is accepted as a fresh byte
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            r_buf       <= 8'h00;
            r_full      <= 1'b0;
            r_overrun   <= 1'b0;
            r_dlv_state <= DLV_EMPTY;
            r_wait_cnt  <= 2'd0;
            r_rx_strobe <= 1'b0;
        end else begin
            r_overrun   <= 1'b0;
            r_dlv_state <= w_dlv_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_rx_strobe <= w_rx_strobe;
            if (w_rx_store) begin
                if (!r_full || w_buf_clear) begin
                    r_buf  <= r_rx_shift;
                    r_full <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_buf_clear) begin
                r_full <= 1'b0;
            end
        end
    end

    assign oRxData   = r_buf;
    assign oRx       = r_rx_strobe;
    assign oFrameErr = r_frame_err;
    assign oOverrun  = r_overrun;

    // ------------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------------
    tx_state_t  r_tx_state;
    tx_state_t  w_tx_state_nxt;
    logic [7:0] r_tx_shift;
    logic [7:0] w_tx_shift_nxt;
    logic [2:0] r_tx_idx;
    logic [2:0] w_tx_idx_nxt;
    logic       w_tx_load;
    logic       w_tx_tc;
    logic       r_tx_line;
    logic       w_tx_line_nxt;
    logic       r_tx_ready;

    uart_bit_timer #(
        .WIDTH    (c_CNT_W)
    ) u_tx_timer (
        .iClk     (iClk),
        .iRstN    (iRstN),
        .iLoad    (w_tx_load),
        .iLoadVal (c_FULL_LOAD),
        .oTc      (w_tx_tc)
    );

    // TX framing and the registered level for the serial line
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_idx_nxt   = r_tx_idx;
        w_tx_load      = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                // r_tx_ready also blocks the cycle straight after reset
                if (iTx && r_tx_ready) begin
                    w_tx_shift_nxt = iTxData;
                    w_tx_state_nxt = TX_START;
                    w_tx_load      = 1'b1;
                end
            end
            TX_START: begin
                if (w_tx_tc) begin
                    w_tx_state_nxt = TX_DATA;
                    w_tx_idx_nxt   = 3'd0;
                    w_tx_load      = 1'b1;
                end
            end
            TX_DATA: begin
                if (w_tx_tc) begin
                    w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                    w_tx_load      = 1'b1;
                    if (r_tx_idx == c_LAST_BIT_IDX) begin
                        w_tx_state_nxt = TX_STOP;
                    end else begin
                        w_tx_idx_nxt = r_tx_idx + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (w_tx_tc) begin
                    w_tx_state_nxt = TX_IDLE;
                end
            end
            default: begin
                w_tx_state_nxt = TX_IDLE;
            end
        endcase

        case (w_tx_state_nxt)
            TX_START: w_tx_line_nxt = 1'b0;
            TX_DATA:  w_tx_line_nxt = w_tx_shift_nxt[0];
            default:  w_tx_line_nxt = 1'b1;
        endcase
    end

    // TX state register; ready follows the state one cycle late
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= 8'h00;
            r_tx_idx   <= 3'd0;
            r_tx_line  <= 1'b1;
            r_tx_ready <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_idx   <= w_tx_idx_nxt;
            r_tx_line  <= w_tx_line_nxt;
            r_tx_ready <= (w_tx_state_nxt == TX_IDLE);
        end
    end

    assign oUartTx  = r_tx_line;
    assign oTxReady = r_tx_ready;

endmodule
`default_nettype wire

// File: tb/tb_uart_phy.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_phy
// Brief    : Directed self-checking bench for uart_phy at 4 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_phy;

    localparam int CPB = 4;

    logic       iClk     = 1'b0;
    logic       iRstN    = 1'b0;
    logic       iUartRx  = 1'b1;
    logic       iRxReady = 1'b0;
    logic       iRxTaken = 1'b0;
    logic       iTx      = 1'b0;
    logic [7:0] iTxData  = 8'h00;
    logic       oUartTx;
    logic [7:0] oRxData;
    logic       oRx;
    logic       oTxReady;
    logic       oFrameErr;
    logic       oOverrun;

    int n_checks    = 0;
    int n_fail      = 0;
    int rx_pulses   = 0;
    int ferr_pulses = 0;
    int ovr_pulses  = 0;

    always #5 iClk = ~iClk;

    uart_phy #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .iClk      (iClk),
        .iRstN     (iRstN),
        .iUartRx   (iUartRx),
        .oUartTx   (oUartTx),
        .oRxData   (oRxData),
        .oRx       (oRx),
        .iRxReady  (iRxReady),
        .iRxTaken  (iRxTaken),
        .oTxReady  (oTxReady),
        .iTxData   (iTxData),
        .iTx       (iTx),
        .oFrameErr (oFrameErr),
        .oOverrun  (oOverrun)
    );

    // Pulse counters, sampled mid-cycle
    always @(negedge iClk) begin
        if (oRx)       rx_pulses   = rx_pulses + 1;
        if (oFrameErr) ferr_pulses = ferr_pulses + 1;
        if (oOverrun)  ovr_pulses  = ovr_pulses + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    // Drive one frame onto the line; the caller decides the level afterwards
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            iUartRx = f[b];
            step(CPB);
        end
    endtask

    // Wait (bounded) for an oRx strobe, then acknowledge it the next cycle
    task automatic wait_rx(input int budget, output logic seen, output logic [7:0] data);
        seen = 1'b0;
        data = 8'h00;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1);
            if (oRx) begin
                seen = 1'b1;
                data = oRxData;
            end
        end
        if (seen) begin
            step(1);
            iRxTaken = 1'b1;
            step(1);
            iRxTaken = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [39:0] pat;
        int          low_cnt;
        int          zeros;
        int          base_rx;
        int          base_ferr;
        int          base_ovr;
        logic        seen;
        logic [7:0]  d;

        // Reset state
        step(3);
        check("rst_tx_line",  oUartTx,   1'b1);
        check("rst_rx",       oRx,       1'b0);
        check("rst_rx_data",  oRxData,   8'h00);
        check("rst_tx_ready", oTxReady,  1'b0);
        check("rst_ferr",     oFrameErr, 1'b0);
        check("rst_overrun",  oOverrun,  1'b0);
        iRstN = 1'b1;
        step(1);
        check("ready_after_release", oTxReady, 1'b1);

        // Transmit 0x55; a second request mid-frame must be ignored
        iTxData = 8'h55;
        iTx     = 1'b1;
        step(1);
        iTx     = 1'b0;
        pat     = '0;
        low_cnt = 0;
        for (int j = 0; j < 40; j++) begin
            pat[j] = oUartTx;
            if (!oTxReady) low_cnt++;
            iTx     = (j == 10);
            iTxData = 8'h00;
            step(1);
        end
        check("tx_55_wave",       pat,      40'hF0F0F0F0F0);
        check("tx_ready_low",     low_cnt,  40);
        check("tx_ready_back",    oTxReady, 1'b1);
        check("tx_line_idle",     oUartTx,  1'b1);

        // Receive 0xA3 with the core ready, take it the cycle after oRx
        iRxReady  = 1'b1;
        base_rx   = rx_pulses;
        base_ferr = ferr_pulses;
        send_frame(8'hA3, 1'b1);
        wait_rx(20, seen, d);
        check("rx_a3_seen", seen, 1'b1);
        check("rx_a3_data", d,    8'hA3);
        step(12);
        check("rx_a3_single", rx_pulses - base_rx,   1);
        check("rx_a3_noferr", ferr_pulses - base_ferr, 0);

        // Two-cycle glitch is not a start bit
        base_rx   = rx_pulses;
        base_ferr = ferr_pulses;
        iUartRx   = 1'b0;
        step(2);
        iUartRx   = 1'b1;
        step(16);
        check("glitch_no_rx",   rx_pulses - base_rx,     0);
        check("glitch_no_ferr", ferr_pulses - base_ferr, 0);

        // 0x3C with a low stop bit, line held low, then a clean 0x11
        base_rx   = rx_pulses;
        base_ferr = ferr_pulses;
        send_frame(8'h3C, 1'b0);
        iUartRx = 1'b0;
        step(20);
        check("ferr_pulse", ferr_pulses - base_ferr, 1);
        check("ferr_no_rx", rx_pulses - base_rx,     0);
        iUartRx = 1'b1;
        step(6);
        send_frame(8'h11, 1'b1);
        wait_rx(20, seen, d);
        check("after_break_seen", seen, 1'b1);
        check("after_break_data", d,    8'h11);

        // Core not ready: second byte overruns, first byte survives
        iRxReady = 1'b0;
        base_rx  = rx_pulses;
        base_ovr = ovr_pulses;
        send_frame(8'h01, 1'b1);
        step(6);
        send_frame(8'h02, 1'b1);
        step(10);
        check("overrun_pulse",  ovr_pulses - base_ovr, 1);
        check("overrun_no_rx",  rx_pulses - base_rx,   0);
        iRxReady = 1'b1;
        wait_rx(20, seen, d);
        check("overrun_seen", seen, 1'b1);
        check("overrun_keep", d,    8'h01);
        step(20);
        check("overrun_single", rx_pulses - base_rx, 1);

        // Reset during the start bit of 0xFF aborts the frame
        iTxData = 8'hFF;
        iTx     = 1'b1;
        step(1);
        iTx     = 1'b0;
        step(1);
        check("tx_ff_start", oUartTx, 1'b0);
        iRstN = 1'b0;
        step(1);
        check("rst_mid_line",  oUartTx,  1'b1);
        check("rst_mid_ready", oTxReady, 1'b0);
        iRstN = 1'b1;
        step(1);
        check("rst_mid_ready_back", oTxReady, 1'b1);
        zeros = 0;
        for (int j = 0; j < 44; j++) begin
            if (!oUartTx) zeros++;
            step(1);
        end
        check("rst_mid_line_quiet", zeros, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_phy.md
UART_PHY -- requirements
Module: uart_phy

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, iClk cycles per serial bit time (≥4).
REQ-002 SHALL have port iClk, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port iRstN, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port iUartRx, input, 1: asynchronous serial receive line, idle high.
REQ-005 SHALL have port oUartTx, output, 1: serial transmit line, idle high.
REQ-006 SHALL have port oRxData, output, 8: received byte offered to the 8250 core.
REQ-007 SHALL have port oRx, output, 1: one-cycle strobe, oRxData valid.
REQ-008 SHALL have port iRxReady, input, 1: core can accept a byte.
REQ-009 SHALL have port iRxTaken, input, 1: core accepted the offered byte.
REQ-010 SHALL have port oTxReady, output, 1: transmitter idle, may accept a byte.
REQ-011 SHALL have port iTxData, input, 8: byte to transmit.
REQ-012 SHALL have port iTx, input, 1: one-cycle strobe, iTxData valid.
REQ-013 SHALL have port oFrameErr, output, 1: one-cycle pulse, stop bit sampled low.
REQ-014 SHALL have port oOverrun, output, 1: one-cycle pulse, byte dropped because holding buffer full.

Function
REQ-015 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each CLKS_PER_BIT cycles.
REQ-016 iUartRx SHALL pass through a 2-flop synchronizer; receiver sees only the synchronized value.
REQ-017 RX FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-018 IDLE -> START when synchronized line is 0; START waits CLKS_PER_BIT/2 cycles (integer division), then samples: 0 -> DATA, 1 -> IDLE (glitch, no error).
REQ-019 DATA SHALL sample every CLKS_PER_BIT cycles, shifting into bit 7 (LSB-first); after 8 samples -> STOP.
REQ-020 STOP SHALL sample after CLKS_PER_BIT cycles: 1 -> store byte, IDLE; 0 -> discard byte, pulse oFrameErr, BREAK.
REQ-021 BREAK -> IDLE only when synchronized line is 1.
REQ-022 Receiver SHALL have a one-byte holding buffer with a full flag.
REQ-023 Store into empty buffer SHALL set full; store into full buffer SHALL keep the old byte and pulse oOverrun.
REQ-024 Delivery FSM: EMPTY, OFFER, WAIT.
REQ-025 OFFER: when full and iRxReady, drive oRx high for exactly one cycle with oRxData = buffer, then WAIT.
REQ-026 WAIT: iRxTaken within 2 cycles after the oRx cycle -> clear full, EMPTY; otherwise back to OFFER, reoffer the same byte when iRxReady.
REQ-027 A store completing in the same cycle the buffer clears SHALL be accepted, no overrun.
REQ-028 oTxReady SHALL be 1 only when TX FSM is IDLE; it SHALL be 0 from the cycle after iTx is accepted.
REQ-029 iTx while oTxReady=1 SHALL latch iTxData and start a frame on oUartTx the next cycle.
REQ-030 iTx while oTxReady=0 SHALL be ignored.
REQ-031 TX FSM states SHALL be IDLE, START, DATA, STOP; oTxReady reasserts the cycle after the full stop bit time ends.
REQ-032 Bit counters SHALL be sized $clog2(CLKS_PER_BIT); bit index 3 bits; no wrap beyond 7.
REQ-033 RX and TX SHALL operate independently and concurrently (full duplex).

Reset
REQ-034 With iRstN=0 at a rising edge: oUartTx=1, oRx=0, oRxData=0, oTxReady=0, oFrameErr=0, oOverrun=0, all FSMs IDLE/EMPTY, buffer empty, synchronizer flops=1.
REQ-035 oTxReady SHALL be 1 on the first cycle after reset release.
REQ-036 Reset mid-frame SHALL abort both directions; a partial RX byte is never delivered.

Structure
REQ-037 RX/TX/delivery state enums and the 8N1 bit-count constants SHALL live in shared package uart_pkg.
REQ-038 The single sub-module SHALL be uart_bit_timer (reloadable down-counter with terminal-count pulse), instanced once for RX and once for TX.

Verification (CLKS_PER_BIT=4)
REQ-039 iTx with 0x55 -> oUartTx 0,1,0,1,0,1,0,1,0,1, each level 4 cycles; oTxReady low 40 cycles.
REQ-040 0xA3 framed onto iUartRx with iRxReady=1 -> one oRx pulse, oRxData=0xA3; iRxTaken next cycle -> buffer empty.
REQ-041 2-cycle low glitch on iUartRx -> no oRx, no oFrameErr; receiver back in IDLE.
REQ-042 Frame 0x3C with stop bit 0 -> oFrameErr pulse, no oRx; line held low 20 cycles, then 0x11 received correctly.
REQ-043 iRxReady=0, frames 0x01 then 0x02 -> oOverrun pulse once; iRxReady=1 -> oRxData=0x01.
REQ-044 Reset asserted mid-TX of 0xFF -> oUartTx=1 next cycle, oTxReady=1 after release.
